// File: rtl/btn_event_ctrl.sv
// Button event controller: turns a debounced button level into press/release/long-press
// strobes and steps a mode index, handing each new mode to a config block via req/ack.
module btn_event_ctrl #(
    parameter int LONG_CYCLES = 100000000,
    parameter int NUM_MODES   = 4,
    parameter int MODE_W      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_db,
    input  logic              cfg_ack,
    output logic              press_pulse,
    output logic              release_pulse,
    output logic              long_pulse,
    output logic [MODE_W-1:0] mode,
    output logic              cfg_req
);

    localparam int                CNT_W     = $clog2(LONG_CYCLES + 1);
    localparam logic [CNT_W-1:0]  LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [MODE_W-1:0] MODE_MAX  = MODE_W'(NUM_MODES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HELD,
        S_LONG
    } state_t;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_INC,
        REQ_ZERO
    } mode_req_t;

    state_t            r_state;
    logic              r_btn_q;
    logic [CNT_W-1:0]  r_hold_cnt;
    logic              r_press;
    logic              r_release;
    logic              r_long;
    logic [MODE_W-1:0] r_mode;
    logic              r_cfg_req;

    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_press_nxt;
    logic              w_release_nxt;
    logic              w_long_nxt;
    mode_req_t         w_mode_req;
    logic              w_rise;
    logic              w_fall;
    logic [MODE_W-1:0] w_mode_inc;

    assign w_rise     = btn_db & ~r_btn_q;
    assign w_fall     = ~btn_db & r_btn_q;
    assign w_mode_inc = (r_mode == MODE_MAX) ? '0 : r_mode + MODE_W'(1);

    // NOTE: every sequential block uses non-blocking assignments so all registers
    // sample the same pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_btn_q    <= 1'b0;
            r_hold_cnt <= '0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_long     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_btn_q    <= btn_db;
            r_hold_cnt <= w_cnt_nxt;
            r_press    <= w_press_nxt;
            r_release  <= w_release_nxt;
            r_long     <= w_long_nxt;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_hold_cnt;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_long_nxt    = 1'b0;
        w_mode_req    = REQ_NONE;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_rise) begin
                    w_state_nxt = S_HELD;
                    w_cnt_nxt   = CNT_W'(1);
                    w_press_nxt = 1'b1;
                end
            end
            S_HELD: begin
                if (w_fall) begin
                    w_state_nxt   = S_IDLE;
                    w_cnt_nxt     = '0;
                    w_release_nxt = 1'b1;
                    w_mode_req    = REQ_INC;
                end else if (btn_db) begin
                    w_cnt_nxt = r_hold_cnt + CNT_W'(1);
                    if (r_hold_cnt == LONG_LAST) begin
                        w_state_nxt = S_LONG;
                        w_long_nxt  = 1'b1;
                        w_mode_req  = REQ_ZERO;
                    end
                end
            end
            S_LONG: begin
                // Counter sits at LONG_CYCLES here; it is never advanced past it.
                if (w_fall) begin
                    w_state_nxt   = S_IDLE;
                    w_cnt_nxt     = '0;
                    w_release_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // A pending request blocks new ones, including one arriving on the ack edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode    <= '0;
            r_cfg_req <= 1'b0;
        end else if (r_cfg_req) begin
            if (cfg_ack) begin
                r_cfg_req <= 1'b0;
            end
        end else if (w_mode_req != REQ_NONE) begin
            r_cfg_req <= 1'b1;
            r_mode    <= (w_mode_req == REQ_ZERO) ? '0 : w_mode_inc;
        end
    end

    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign long_pulse    = r_long;
    assign mode          = r_mode;
    assign cfg_req       = r_cfg_req;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl (LONG_CYCLES=8, NUM_MODES=3): short presses, mode wrap,
// long press, requests while pending, and reset in the middle of a hold.
module tb_btn_event_ctrl;

    localparam int LONG = 8;
    localparam int NM   = 3;
    localparam int MW   = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          btn_db;
    logic          cfg_ack;
    logic          press_pulse;
    logic          release_pulse;
    logic          long_pulse;
    logic [MW-1:0] mode;
    logic          cfg_req;

    int tests = 0;
    int fails = 0;
    int n_press = 0;
    int n_rel   = 0;
    int n_long  = 0;
    logic prev_press = 1'b0;
    logic prev_rel   = 1'b0;
    logic prev_long  = 1'b0;

    btn_event_ctrl #(
        .LONG_CYCLES(LONG),
        .NUM_MODES  (NM),
        .MODE_W     (MW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_db       (btn_db),
        .cfg_ack      (cfg_ack),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .mode         (mode),
        .cfg_req      (cfg_req)
    );

    always #5 clk = ~clk;

    // Pulse counters and single-cycle width checks, sampled mid-cycle.
    always @(negedge clk) begin
        if (press_pulse) begin
            n_press++;
            tests++;
            if (prev_press) begin
                fails++;
                $display("FAIL press_width: pulse high for 2+ cycles at %0t", $time);
            end
        end
        if (release_pulse) begin
            n_rel++;
            tests++;
            if (prev_rel) begin
                fails++;
                $display("FAIL release_width: pulse high for 2+ cycles at %0t", $time);
            end
        end
        if (long_pulse) begin
            n_long++;
            tests++;
            if (prev_long) begin
                fails++;
                $display("FAIL long_width: pulse high for 2+ cycles at %0t", $time);
            end
        end
        prev_press = press_pulse;
        prev_rel   = release_pulse;
        prev_long  = long_pulse;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic press_and_ack();
        btn_db = 1'b1;
        tick();
        tick();
        btn_db = 1'b0;
        tick();
        tick();
        cfg_ack = 1'b1;
        tick();
        cfg_ack = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        btn_db  = 1'b0;
        cfg_ack = 1'b0;
        #1;
        tests++;
        if ({press_pulse, release_pulse, long_pulse, mode, cfg_req} !== 6'b0) begin
            fails++;
            $display("FAIL reset_async: outputs=%b expected 000000",
                     {press_pulse, release_pulse, long_pulse, mode, cfg_req});
        end
        repeat (3) tick();
        rst = 1'b0;
        tick();
        tests++;
        if ({press_pulse, release_pulse, long_pulse, mode, cfg_req} !== 6'b0) begin
            fails++;
            $display("FAIL reset_after: outputs=%b expected 000000",
                     {press_pulse, release_pulse, long_pulse, mode, cfg_req});
        end
    endtask

    task automatic test_short_press();
        int p0 = n_press;
        int r0 = n_rel;
        int l0 = n_long;
        btn_db = 1'b1;
        tick();
        tests++;
        if (press_pulse !== 1'b1 || mode !== 2'd0) begin
            fails++;
            $display("FAIL short_press_pulse: press=%b mode=%0d expected press=1 mode=0",
                     press_pulse, mode);
        end
        tick();
        tick();
        btn_db = 1'b0;
        tick();
        tests++;
        if (release_pulse !== 1'b1 || mode !== 2'd1 || cfg_req !== 1'b1) begin
            fails++;
            $display("FAIL short_release: rel=%b mode=%0d req=%b expected 1/1/1",
                     release_pulse, mode, cfg_req);
        end
        tick();
        tests++;
        if (cfg_req !== 1'b1) begin
            fails++;
            $display("FAIL short_req_hold: cfg_req=%b expected 1", cfg_req);
        end
        cfg_ack = 1'b1;
        tick();
        tests++;
        if (cfg_req !== 1'b0) begin
            fails++;
            $display("FAIL short_ack_clear: cfg_req=%b expected 0", cfg_req);
        end
        cfg_ack = 1'b0;
        repeat (3) tick();
        tests++;
        if (n_press - p0 != 1 || n_rel - r0 != 1 || n_long - l0 != 0 || mode !== 2'd1) begin
            fails++;
            $display("FAIL short_counts: press=%0d rel=%0d long=%0d mode=%0d expected 1/1/0/1",
                     n_press - p0, n_rel - r0, n_long - l0, mode);
        end
    endtask

    task automatic test_mode_wrap();
        int exp_mode[3] = '{1, 2, 0};
        int handshakes  = 0;
        apply_reset();
        tick();
        for (int i = 0; i < 3; i++) begin
            bit seen = 1'b0;
            btn_db = 1'b1;
            tick();
            tick();
            btn_db = 1'b0;
            for (int c = 0; c < 4 && !seen; c++) begin
                tick();
                if (cfg_req === 1'b1) seen = 1'b1;
            end
            tests++;
            if (!seen) begin
                fails++;
                $display("FAIL wrap_req_timeout: press %0d got no cfg_req within 4 cycles", i);
            end
            tests++;
            if (mode !== MW'(exp_mode[i])) begin
                fails++;
                $display("FAIL wrap_mode: press %0d mode=%0d expected %0d", i, mode, exp_mode[i]);
            end
            tick();
            cfg_ack = 1'b1;
            tick();
            cfg_ack = 1'b0;
            if (cfg_req === 1'b0 && seen) handshakes++;
            tick();
        end
        tests++;
        if (handshakes != 3) begin
            fails++;
            $display("FAIL wrap_handshakes: got %0d expected 3", handshakes);
        end
    endtask

    task automatic test_long_press();
        int p0, r0, l0;
        press_and_ack();
        press_and_ack();
        tests++;
        if (mode !== 2'd2 || cfg_req !== 1'b0) begin
            fails++;
            $display("FAIL long_setup: mode=%0d req=%b expected 2/0", mode, cfg_req);
        end
        p0 = n_press;
        r0 = n_rel;
        l0 = n_long;
        btn_db = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 1) begin
                tests++;
                if (press_pulse !== 1'b1) begin
                    fails++;
                    $display("FAIL long_press_pulse: press=%b expected 1", press_pulse);
                end
            end
            if (i == 7) begin
                tests++;
                if (long_pulse !== 1'b0 || mode !== 2'd2) begin
                    fails++;
                    $display("FAIL long_early: long=%b mode=%0d expected 0/2", long_pulse, mode);
                end
            end
            if (i == 8) begin
                tests++;
                if (long_pulse !== 1'b1 || mode !== 2'd0 || cfg_req !== 1'b1) begin
                    fails++;
                    $display("FAIL long_fire: long=%b mode=%0d req=%b expected 1/0/1",
                             long_pulse, mode, cfg_req);
                end
            end
            if (i == 10) cfg_ack = 1'b1;
            if (i == 11) begin
                cfg_ack = 1'b0;
                tests++;
                if (cfg_req !== 1'b0) begin
                    fails++;
                    $display("FAIL long_ack: cfg_req=%b expected 0", cfg_req);
                end
            end
        end
        btn_db = 1'b0;
        tick();
        tests++;
        if (release_pulse !== 1'b1 || mode !== 2'd0 || cfg_req !== 1'b0) begin
            fails++;
            $display("FAIL long_release: rel=%b mode=%0d req=%b expected 1/0/0",
                     release_pulse, mode, cfg_req);
        end
        repeat (3) tick();
        tests++;
        if (n_press - p0 != 1 || n_rel - r0 != 1 || n_long - l0 != 1 || mode !== 2'd0
            || cfg_req !== 1'b0) begin
            fails++;
            $display("FAIL long_counts: press=%0d rel=%0d long=%0d mode=%0d req=%b expected 1/1/1/0/0",
                     n_press - p0, n_rel - r0, n_long - l0, mode, cfg_req);
        end
    endtask

    task automatic test_back_to_back();
        btn_db = 1'b1;
        tick();
        tick();
        btn_db = 1'b0;
        tick();
        tests++;
        if (mode !== 2'd1 || cfg_req !== 1'b1) begin
            fails++;
            $display("FAIL b2b_first: mode=%0d req=%b expected 1/1", mode, cfg_req);
        end
        tick();
        btn_db = 1'b1;
        tick();
        tests++;
        if (press_pulse !== 1'b1) begin
            fails++;
            $display("FAIL b2b_press: press=%b expected 1", press_pulse);
        end
        tick();
        btn_db = 1'b0;
        tick();
        tests++;
        if (release_pulse !== 1'b1 || mode !== 2'd1 || cfg_req !== 1'b1) begin
            fails++;
            $display("FAIL b2b_dropped: rel=%b mode=%0d req=%b expected 1/1/1",
                     release_pulse, mode, cfg_req);
        end
        tick();
        // Release lands on the same edge as the ack: the new request is dropped.
        btn_db = 1'b1;
        tick();
        tick();
        btn_db  = 1'b0;
        cfg_ack = 1'b1;
        tick();
        tests++;
        if (release_pulse !== 1'b1 || mode !== 2'd1 || cfg_req !== 1'b0) begin
            fails++;
            $display("FAIL b2b_ack_edge: rel=%b mode=%0d req=%b expected 1/1/0",
                     release_pulse, mode, cfg_req);
        end
        tick();
        cfg_ack = 1'b0;
        tick();
        tests++;
        if (mode !== 2'd1 || cfg_req !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle_ack: mode=%0d req=%b expected 1/0", mode, cfg_req);
        end
    endtask

    task automatic test_reset_mid_hold();
        int l0 = n_long;
        btn_db = 1'b1;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        tests++;
        if ({press_pulse, release_pulse, long_pulse, mode, cfg_req} !== 6'b0) begin
            fails++;
            $display("FAIL rst_hold_async: outputs=%b expected 000000",
                     {press_pulse, release_pulse, long_pulse, mode, cfg_req});
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++;
            if ({press_pulse, release_pulse, long_pulse, mode, cfg_req} !== 6'b0) begin
                fails++;
                $display("FAIL rst_hold_during: cycle %0d outputs=%b expected 000000", i,
                         {press_pulse, release_pulse, long_pulse, mode, cfg_req});
            end
        end
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 1) begin
                tests++;
                if (press_pulse !== 1'b1) begin
                    fails++;
                    $display("FAIL rst_hold_press: press=%b expected 1", press_pulse);
                end
            end
            if (i == 7) begin
                tests++;
                if (long_pulse !== 1'b0) begin
                    fails++;
                    $display("FAIL rst_hold_early_long: long=%b expected 0", long_pulse);
                end
            end
            if (i == 8) begin
                tests++;
                if (long_pulse !== 1'b1 || mode !== 2'd0 || cfg_req !== 1'b1) begin
                    fails++;
                    $display("FAIL rst_hold_long: long=%b mode=%0d req=%b expected 1/0/1",
                             long_pulse, mode, cfg_req);
                end
            end
        end
        btn_db = 1'b0;
        tick();
        cfg_ack = 1'b1;
        tick();
        cfg_ack = 1'b0;
        tick();
        tests++;
        if (n_long - l0 != 1 || cfg_req !== 1'b0) begin
            fails++;
            $display("FAIL rst_hold_counts: long=%0d req=%b expected 1/0", n_long - l0, cfg_req);
        end
    endtask

    initial begin
        test_reset();
        test_short_press();
        test_mode_wrap();
        test_long_press();
        test_back_to_back();
        test_reset_mid_hold();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
